// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: opcodes, flag bit indices, FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_SHR  = 3'b001,
    OP_MOV  = 3'b010,
    OP_EXCH = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } alu_op_e;

  // Bit positions inside the {Z,N,C} flag register.
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between an issuing master and the ALU unit.
interface alu_exec_unit_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic [2:0]        znc;

  modport master (
    output in_valid, op, ra, rb, out_ready,
    input  in_ready, out_valid, res_a, res_b, znc
  );

  modport slave (
    input  in_valid, op, ra, rb, out_ready,
    output in_ready, out_valid, res_a, res_b, znc
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Bit-serial logical right shifter: one position per step until the count runs out.
module alu_shift_seq #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_amount,
  input  logic               i_step,
  output logic [DATA_W-1:0]  o_data_nxt,
  output logic               o_done,
  output logic               o_last_out_bit
);

  logic [DATA_W-1:0]  r_data;
  logic [SHAMT_W-1:0] r_count;

  // Operand/count capture on load, then one shift per step while count is non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_count <= i_amount;
    end else if (i_step && (r_count != '0)) begin
      r_data  <= o_data_nxt;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

  // Step result is exposed combinationally so the final step can be registered directly.
  assign o_data_nxt     = r_data >> 1;
  assign o_last_out_bit = r_data[0];
  assign o_done         = (r_count == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with valid/ready handshakes; SHR runs bit-serially, everything else in 1 cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  logic [0:0]         r_state;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_res_a;
  logic [DATA_W-1:0]  r_res_b;
  logic [2:0]         r_znc;

  logic               w_in_ready;
  logic               w_accept;
  logic [SHAMT_W-1:0] w_amount;
  logic               w_shr_multi;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W:0]    w_diff;
  logic [DATA_W-1:0]  w_res_a;
  logic [DATA_W-1:0]  w_res_b;
  logic               w_c;
  logic               w_flags_upd;
  logic [2:0]         w_znc;
  logic [2:0]         w_shift_znc;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               w_shift_bit;
  logic               w_shift_done;
  logic               w_in_shift;

  assign w_in_shift  = (r_state == ST_SHIFT);
  assign w_in_ready  = !w_in_shift && (!r_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_amount    = bus.rb[SHAMT_W-1:0];
  assign w_shr_multi = (bus.op == OP_SHR) && (w_amount != '0);

  alu_shift_seq #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk            (clk),
    .rst            (rst),
    .i_load         (w_accept && w_shr_multi),
    .i_data         (bus.ra),
    .i_amount       (w_amount),
    .i_step         (w_in_shift),
    .o_data_nxt     (w_shift_nxt),
    .o_done         (w_shift_done),
    .o_last_out_bit (w_shift_bit)
  );

  // Single-cycle datapath; SHR here only covers the zero-amount case (pass-through, C kept).
  always_comb begin
    w_sum       = {1'b0, bus.ra} + {1'b0, bus.rb};
    w_diff      = {1'b0, bus.ra} - {1'b0, bus.rb};
    w_res_a     = bus.ra;
    w_res_b     = bus.rb;
    w_c         = r_znc[FLAG_C];
    w_flags_upd = 1'b1;
    case (bus.op)
      OP_ADD: begin
        w_res_a = w_sum[DATA_W-1:0];
        w_c     = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_res_a = w_diff[DATA_W-1:0];
        w_c     = w_diff[DATA_W];
      end
      OP_OR: begin
        w_res_a = bus.ra | bus.rb;
        w_c     = 1'b0;
      end
      OP_AND: begin
        w_res_a = bus.ra & bus.rb;
        w_c     = 1'b0;
      end
      OP_XOR: begin
        w_res_a = bus.ra ^ bus.rb;
        w_c     = 1'b0;
      end
      OP_MOV: begin
        w_res_b     = bus.ra;
        w_flags_upd = 1'b0;
      end
      OP_EXCH: begin
        w_res_a     = bus.rb;
        w_res_b     = bus.ra;
        w_flags_upd = 1'b0;
      end
      default: ;
    endcase
  end

  // Flag values for the immediate path and for the final serial-shift step.
  always_comb begin
    w_znc               = r_znc;
    w_shift_znc         = '0;
    if (w_flags_upd) begin
      w_znc[FLAG_Z]     = (w_res_a == '0);
      w_znc[FLAG_N]     = w_res_a[DATA_W-1];
      w_znc[FLAG_C]     = w_c;
    end
    w_shift_znc[FLAG_Z] = (w_shift_nxt == '0);
    w_shift_znc[FLAG_N] = w_shift_nxt[DATA_W-1];
    w_shift_znc[FLAG_C] = w_shift_bit;
  end

  // Control FSM and result/flag registers; results only move when a new one is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_res_a     <= '0;
      r_res_b     <= '0;
      r_znc       <= '0;
    end else if (w_accept) begin
      if (w_shr_multi) begin
        r_state     <= ST_SHIFT;
        r_out_valid <= 1'b0;
        r_res_b     <= bus.rb;
      end else begin
        r_out_valid <= 1'b1;
        r_res_a     <= w_res_a;
        r_res_b     <= w_res_b;
        r_znc       <= w_znc;
      end
    end else if (w_in_shift && w_shift_done) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b1;
      r_res_a     <= w_shift_nxt;
      r_znc       <= w_shift_znc;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res_a     = r_res_a;
  assign bus.res_b     = r_res_b;
  assign bus.znc       = r_znc;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + random bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned DW = 16;
  localparam logic [2:0] T_XOR = 3'b000, T_SHR = 3'b001, T_MOV = 3'b010, T_EXCH = 3'b011;
  localparam logic [2:0] T_ADD = 3'b100, T_SUB = 3'b101, T_OR = 3'b110, T_AND = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_W(DW)) bus ();

  alu_exec_unit #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  m_znc;
  logic [15:0] obs_a, obs_b;
  logic [2:0]  obs_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] zin, output logic [15:0] ea,
                                output logic [15:0] eb, output logic [2:0] ez, output int lat);
    int   s   = int'(b % 16);
    int   sum;
    logic c   = zin[0];
    logic upd = 1'b1;
    ea  = a;
    eb  = b;
    lat = 1;
    case (op)
      T_ADD: begin sum = int'(a) + int'(b); ea = 16'(sum); c = (sum > 65535); end
      T_SUB: begin ea = 16'(int'(a) - int'(b)); c = (a < b); end
      T_OR:  begin ea = a | b; c = 1'b0; end
      T_AND: begin ea = a & b; c = 1'b0; end
      T_XOR: begin ea = a ^ b; c = 1'b0; end
      T_SHR: if (s > 0) begin ea = a >> s; c = a[s-1]; lat = s + 1; end
      T_MOV: begin eb = a; upd = 1'b0; end
      default: begin ea = b; eb = a; upd = 1'b0; end
    endcase
    ez = upd ? {ea == 16'h0, ea[15], c} : zin;
  endfunction

  // Issue one op, wait for its result, optionally stall the consumer, then deliver it.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall);
    logic [15:0] ea, eb;
    logic [2:0]  ez;
    int          lat, guard, olat, busy;
    model(op, a, b, m_znc, ea, eb, ez, lat);
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.ra        = a;
    bus.rb        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.ra       = 16'($urandom);
    bus.rb       = 16'($urandom);
    olat = 0;
    busy = 0;
    do begin
      @(negedge clk);
      olat++;
      if (!bus.out_valid && !bus.in_ready) busy++;
    end while (!bus.out_valid && olat < 40);
    obs_a = bus.res_a;
    obs_b = bus.res_b;
    obs_z = bus.znc;
    chk("latency", 32'(olat), 32'(lat));
    chk("busy_cycles", 32'(busy), 32'(lat - 1));
    chk("res_a", 32'(obs_a), 32'(ea));
    chk("res_b", 32'(obs_b), 32'(eb));
    chk("znc", 32'(obs_z), 32'(ez));
    m_znc = ez;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_res_a", 32'(bus.res_a), 32'(ea));
      chk("stall_znc", 32'(bus.znc), 32'(ez));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin : main
    logic [15:0] a, b, a2, b2, ea, eb, ea2, eb2;
    logic [2:0]  ez, ez2, op;
    logic [15:0] xa [8];
    logic [15:0] xb [8];
    int          lat, seen;

    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.ra        = '0;
    bus.rb        = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    m_znc         = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_res_a", 32'(bus.res_a), 32'd0);
    chk("reset_res_b", 32'(bus.res_b), 32'd0);
    chk("reset_znc", 32'(bus.znc), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Spot vectors with hand-derived results.
    run_op(T_ADD, 16'hFFFF, 16'h0001, 0);
    chk("add_vec_a", 32'(obs_a), 32'h0000);
    chk("add_vec_z", 32'(obs_z), 32'b101);
    run_op(T_SUB, 16'h0003, 16'h0005, 0);
    chk("sub_vec_a", 32'(obs_a), 32'hFFFE);
    chk("sub_vec_z", 32'(obs_z), 32'b011);
    run_op(T_EXCH, 16'h1234, 16'hABCD, 0);
    chk("exch_vec_a", 32'(obs_a), 32'hABCD);
    chk("exch_vec_b", 32'(obs_b), 32'h1234);
    chk("exch_vec_z", 32'(obs_z), 32'b011);
    run_op(T_SHR, 16'h8003, 16'h0002, 0);
    chk("shr_vec_a", 32'(obs_a), 32'h2000);
    chk("shr_vec_z", 32'(obs_z), 32'b001);

    // Stalled AND result, then release together with a new ADD on the same edge.
    a  = 16'($urandom);
    b  = 16'($urandom);
    a2 = 16'($urandom);
    b2 = 16'($urandom);
    model(T_AND, a, b, m_znc, ea, eb, ez, lat);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = T_AND;
    bus.ra        = a;
    bus.rb        = b;
    @(posedge clk);
    #1;
    bus.op = T_ADD;
    bus.ra = a2;
    bus.rb = b2;
    @(negedge clk);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_res_a", 32'(bus.res_a), 32'(ea));
    chk("bp_znc", 32'(bus.znc), 32'(ez));
    m_znc = ez;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_a", 32'(bus.res_a), 32'(ea));
      chk("bp_hold_b", 32'(bus.res_b), 32'(eb));
      chk("bp_hold_z", 32'(bus.znc), 32'(ez));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    model(T_ADD, a2, b2, m_znc, ea2, eb2, ez2, lat);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_a", 32'(bus.res_a), 32'(ea2));
    chk("bp_next_z", 32'(bus.znc), 32'(ez2));
    m_znc = ez2;
    @(negedge clk);
    chk("bp_next_drop", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a 15-step shift.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = T_SHR;
    bus.ra       = 16'hFFFF;
    bus.rb       = 16'h000F;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("shr_busy_before_rst", 32'(bus.in_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_a", 32'(bus.res_a), 32'd0);
    chk("rst_async_b", 32'(bus.res_b), 32'd0);
    chk("rst_async_z", 32'(bus.znc), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    m_znc = 3'b000;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rst_no_result", 32'(seen), 32'd0);
    run_op(T_ADD, 16'($urandom), 16'($urandom), 0);

    // Eight back-to-back XORs with a free-running consumer.
    for (int i = 0; i < 8; i++) begin
      xa[i] = 16'($urandom);
      xb[i] = 16'($urandom);
    end
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        model(T_XOR, xa[i-1], xb[i-1], m_znc, ea, eb, ez, lat);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_res_a", 32'(bus.res_a), 32'(ea));
        chk("b2b_znc", 32'(bus.znc), 32'(ez));
        chk("b2b_carry", 32'(bus.znc[0]), 32'd0);
        m_znc = ez;
      end
      if (i < 8) begin
        bus.in_valid = 1'b1;
        bus.op       = T_XOR;
        bus.ra       = xa[i];
        bus.rb       = xb[i];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_drop", 32'(bus.out_valid), 32'd0);

    // Random ops with occasional consumer stalls.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      run_op(op, 16'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0) ? 1 + int'($urandom_range(0, 1)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width in bits (>=4).
REQ-002 Parameter SHAMT_W, default $clog2(DATA_W), width of shift-amount field taken from rb.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  operation request present.
REQ-007 in_ready  out  1  unit can accept an operation this cycle.
REQ-008 op  in  3  opcode: 100 ADD, 101 SUB, 110 OR, 111 AND, 000 XOR, 001 SHR, 010 MOV, 011 EXCH.
REQ-009 ra  in  DATA_W  operand A.
REQ-010 rb  in  DATA_W  operand B; rb[SHAMT_W-1:0] is the shift amount for SHR.
REQ-011 out_valid  out  1  result registers hold an undelivered result.
REQ-012 out_ready  in  1  consumer takes result this cycle.
REQ-013 res_a  out  DATA_W  result for register A.
REQ-014 res_b  out  DATA_W  result for register B.
REQ-015 znc  out  3  flag register {Z,N,C}, bit 2 = Z.

Function
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 only in state IDLE and when (!out_valid || out_ready).
REQ-018 States: IDLE, SHIFT; IDLE->SHIFT on accepted SHR with amount>0; SHIFT->IDLE when remaining count reaches 0.
REQ-019 Non-SHR ops and SHR with amount 0: result and flags registered at accept edge; out_valid=1 the next cycle (latency 1).
REQ-020 SHR amount s>0: one bit logical right shift per cycle in SHIFT; out_valid=1 s+1 cycles after accept edge.
REQ-021 ADD: res_a=ra+rb mod 2^DATA_W; C=carry-out; res_b=rb.
REQ-022 SUB: res_a=ra-rb mod 2^DATA_W; C=1 iff borrow (ra<rb unsigned); res_b=rb.
REQ-023 OR/AND/XOR: res_a=bitwise op; C cleared to 0; res_b=rb.
REQ-024 SHR: res_a=ra>>s, zero fill; C=last bit shifted out; s=0 -> res_a=ra, C unchanged; res_b=rb.
REQ-025 ADD/SUB/OR/AND/XOR/SHR SHALL set Z=(res_a==0), N=res_a[DATA_W-1].
REQ-026 MOV: res_a=ra, res_b=ra; EXCH: res_a=rb, res_b=ra; both leave znc unchanged.
REQ-027 znc SHALL update exactly once per operation, at the cycle out_valid rises; it holds otherwise.
REQ-028 res_a/res_b/znc SHALL remain stable while out_valid && !out_ready.
REQ-029 out_valid falls after transfer out unless a new 1-cycle op is accepted on the same edge (back-to-back throughput 1/cycle).
REQ-030 in_valid, op, ra, rb are ignored when in_ready=0; operands captured at accept, later changes have no effect.

Reset
REQ-031 rst SHALL force state=IDLE, out_valid=0, res_a=0, res_b=0, znc=000, shift count=0, immediately and asynchronously.
REQ-032 rst asserted mid-SHIFT SHALL abort the operation with no result delivered; in_ready=1 the first cycle after rst deasserts.

Structure
REQ-033 Opcode encodings, flag bit indices and state enum SHALL live in shared package alu_pkg.
REQ-034 Shift datapath SHALL be sub-module alu_shift_seq (load, step, count, done, last_out_bit); remaining logic is flat.

Verification (DATA_W=16)
REQ-035 ADD ra=FFFF rb=0001 -> res_a=0000, res_b=0001, znc=101, out_valid one cycle after accept.
REQ-036 SUB ra=0003 rb=0005 -> res_a=FFFE, znc=011; then EXCH ra=1234 rb=ABCD -> res_a=ABCD, res_b=1234, znc still 011.
REQ-037 SHR ra=8003 rb=0002 -> in_ready=0 for 2 cycles, out_valid 3 cycles after accept, res_a=2000, znc=001.
REQ-038 out_ready=0 for 3 cycles on a pending AND result -> outputs stable, in_ready=0; raise out_ready with in_valid -> new op accepted same edge.
REQ-039 rst asserted during SHR ra=FFFF rb=000F at cycle 5 -> all outputs 0 at once, no out_valid pulse, next ADD completes normally.
REQ-040 Back-to-back 8 XOR ops with out_ready=1 -> 8 results on 8 consecutive cycles, C=0 on each.
